// File: rtl/skinny_sbox8_pkg.sv
// skinny_sbox8_pkg: shared constants, carry-register types and reference helpers
//   for the masked SKINNY-128 S-box pipeline.
package skinny_sbox8_pkg;
  localparam int SBOX8_LAT   = 8;
  localparam int SBOX8_RBITS = 8;
  // Output bit position taken by intermediate ai (a0->6, a1->5, ... a7->0).
  localparam int SBOX8_OUT_POS [8] = '{6, 5, 2, 7, 3, 1, 4, 0};
  // Carry registers between layers; x = input-share bits, r = mask bits, a = intermediates.
  // c1: x {b7,b5,b3,b2,b1}, r {r7..r3}
  typedef struct packed {
    logic [4:0] x0, x1, r;
  } c1_t;
  // c2: x {b7,b3,b2}, r {r7,r6,r5}, a {a2,a1,a0}
  typedef struct packed {
    logic [2:0] x0, x1, r, a0, a1;
  } c2_t;
  // c3: x b2, r r7, a {a4..a0}
  typedef struct packed {
    logic       x0, x1, r;
    logic [4:0] a0, a1;
  } c3_t;
  // c4: a {a6..a0}
  typedef struct packed {
    logic [6:0] a0, a1;
  } c4_t;
  function automatic logic [7:0] sbox8_perm(input logic [7:0] a);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) o[SBOX8_OUT_POS[i]] = a[i];
    return o;
  endfunction
  // Unmasked reference S8, for verification use only.
  function automatic logic [7:0] sbox8_ref(input logic [7:0] b);
    logic [7:0] a;
    a[0] = ~(b[7] | b[6]) ^ b[4];
    a[1] = ~(b[3] | b[2]) ^ b[0];
    a[2] = ~(b[2] | b[1]) ^ b[6];
    a[3] = ~(a[0] | a[1]) ^ b[5];
    a[4] = ~(a[1] | b[3]) ^ b[1];
    a[5] = ~(a[2] | a[3]) ^ b[7];
    a[6] = ~(a[3] | a[0]) ^ b[3];
    a[7] = ~(a[4] | a[5]) ^ b[2];
    return sbox8_perm(a);
  endfunction
endpackage

// File: rtl/skinny_sbox8_dom1_sni_pipelined_lanes_cfn.sv
// dom1_sni_cfn_stall: one first-order DOM-Indep masked gate f = ~(x|y)^z, two register levels.
//   clk, rst_n (async active-low), en (load enable, holds when low),
//   x0/x1, y0/y1, z0/z1 input shares, r fresh mask bit, f0/f1 registered output shares.
module dom1_sni_cfn_stall (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic x0,
  input  logic x1,
  input  logic y0,
  input  logic y1,
  input  logic z0,
  input  logic z1,
  input  logic r,
  output logic f0,
  output logic f1
);
  logic g0_d, g1_d, t0_d, t1_d, f0_d, f1_d;
  logic g0_q, g1_q, t0_q, t1_q, f0_q, f1_q;
  // Share 1 is carried inverted so the product of shares yields NOR directly.
  always_comb begin
    g1_d = (~x1 & ~y1) ^ z1;
    g0_d = (x0 & y0) ^ z0;
    t1_d = (~x1 & y0) ^ r;
    t0_d = (~y1 & x0) ^ r;
    f0_d = t0_q ^ g0_q;
    f1_d = t1_q ^ g1_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {g0_q, g1_q, t0_q, t1_q, f0_q, f1_q} <= '0;
    else if (en) {g0_q, g1_q, t0_q, t1_q, f0_q, f1_q} <= {g0_d, g1_d, t0_d, t1_d, f0_d, f1_d};
  assign f0 = f0_q;
  assign f1 = f1_q;
endmodule

// File: rtl/skinny_sbox8_dom1_sni_pipelined_lanes.sv
// skinny_sbox8_dom1_sni_pipelined_lanes: NLANES first-order masked SKINNY-128 S8 S-boxes,
//   8-stage pipeline with valid/ready handshake and global stall.
//   in_valid/r_valid/in_ready: input handshake (word accepted only with fresh randomness),
//   si0/si1: input shares, r: 8 mask bits per lane, out_valid/out_ready: output handshake,
//   bo0/bo1: output shares. Optional SKINNY_SBOX8_RAND_CNT_EN adds rand_cnt (mask bits consumed).
module skinny_sbox8_dom1_sni_pipelined_lanes
  import skinny_sbox8_pkg::*;
#(
  parameter int NLANES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  r_valid,
  input  logic [8*NLANES-1:0]   si0,
  input  logic [8*NLANES-1:0]   si1,
  input  logic [8*NLANES-1:0]   r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NLANES-1:0]   bo0,
  output logic [8*NLANES-1:0]   bo1
`ifdef SKINNY_SBOX8_RAND_CNT_EN
  ,
  output logic [31:0]           rand_cnt
`endif
);
  localparam int LAT = SBOX8_LAT;
  logic adv, accept;
  logic [LAT-1:0] v_d, v_q;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & r_valid & adv;
  assign out_valid = v_q[LAT-1];
  always_comb v_d = {v_q[LAT-2:0], accept};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v_q <= '0;
    else if (adv) v_q <= v_d;
`ifdef SKINNY_SBOX8_RAND_CNT_EN
  localparam logic [32:0] RINC = 33'(SBOX8_RBITS * NLANES);
  logic [31:0] rand_cnt_d, rand_cnt_q;
  logic [32:0] rand_sum;
  always_comb begin
    rand_sum   = {1'b0, rand_cnt_q} + RINC;
    rand_cnt_d = accept ? (rand_sum[32] ? '1 : rand_sum[31:0]) : rand_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rand_cnt_q <= '0;
    else rand_cnt_q <= rand_cnt_d;
  assign rand_cnt = rand_cnt_q;
`else
  localparam int RINC_UNUSED = SBOX8_RBITS;
`endif
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [7:0] x0, x1, rr, gx0, gx1, gy0, gy1, gz0, gz1, gr, af0, af1;
    c1_t c1a_d, c1a_q, c1b_d, c1b_q;
    c2_t c2a_d, c2a_q, c2b_d, c2b_q;
    c3_t c3a_d, c3a_q, c3b_d, c3b_q;
    c4_t c4a_d, c4a_q, c4b_d, c4b_q;
    always_comb begin
      // Bubbles enter as all-zero shares and masks so no stale port data travels.
      x0 = accept ? si0[8*k+:8] : '0;
      x1 = accept ? si1[8*k+:8] : '0;
      rr = accept ? r[8*k+:8]   : '0;
      c1a_d.x0 = {x0[7], x0[5], x0[3], x0[2], x0[1]};
      c1a_d.x1 = {x1[7], x1[5], x1[3], x1[2], x1[1]};
      c1a_d.r  = rr[7:3];
      c1b_d    = c1a_q;
      c2a_d.x0 = {c1b_q.x0[4], c1b_q.x0[2], c1b_q.x0[1]};
      c2a_d.x1 = {c1b_q.x1[4], c1b_q.x1[2], c1b_q.x1[1]};
      c2a_d.r  = c1b_q.r[4:2];
      c2a_d.a0 = af0[2:0];
      c2a_d.a1 = af1[2:0];
      c2b_d    = c2a_q;
      c3a_d.x0 = c2b_q.x0[0];
      c3a_d.x1 = c2b_q.x1[0];
      c3a_d.r  = c2b_q.r[2];
      c3a_d.a0 = {af0[4:3], c2b_q.a0};
      c3a_d.a1 = {af1[4:3], c2b_q.a1};
      c3b_d    = c3a_q;
      c4a_d.a0 = {af0[6:5], c3b_q.a0};
      c4a_d.a1 = {af1[6:5], c3b_q.a1};
      c4b_d    = c4a_q;
      // Gate j computes aj; inputs arranged as {gate7 .. gate0}.
      gx0 = {c3b_q.a0[4], af0[3], c2b_q.a0[2], af0[1], af0[0], x0[2], x0[3], x0[7]};
      gx1 = {c3b_q.a1[4], af1[3], c2b_q.a1[2], af1[1], af1[0], x1[2], x1[3], x1[7]};
      gy0 = {af0[5], c2b_q.a0[0], af0[3], c1b_q.x0[2], af0[1], x0[1], x0[2], x0[6]};
      gy1 = {af1[5], c2b_q.a1[0], af1[3], c1b_q.x1[2], af1[1], x1[1], x1[2], x1[6]};
      gz0 = {c3b_q.x0, c2b_q.x0[1], c2b_q.x0[2], c1b_q.x0[0], c1b_q.x0[3], x0[6], x0[0], x0[4]};
      gz1 = {c3b_q.x1, c2b_q.x1[1], c2b_q.x1[2], c1b_q.x1[0], c1b_q.x1[3], x1[6], x1[0], x1[4]};
      gr  = {c3b_q.r, c2b_q.r[1], c2b_q.r[0], c1b_q.r[1], c1b_q.r[0], rr[2], rr[1], rr[0]};
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        c1a_q <= '0;
        c1b_q <= '0;
        c2a_q <= '0;
        c2b_q <= '0;
        c3a_q <= '0;
        c3b_q <= '0;
        c4a_q <= '0;
        c4b_q <= '0;
      end else if (adv) begin
        c1a_q <= c1a_d;
        c1b_q <= c1b_d;
        c2a_q <= c2a_d;
        c2b_q <= c2b_d;
        c3a_q <= c3a_d;
        c3b_q <= c3b_d;
        c4a_q <= c4a_d;
        c4b_q <= c4b_d;
      end
    for (genvar g = 0; g < 8; g++) begin : g_gate
      dom1_sni_cfn_stall u_cfn (
        .clk(clk), .rst_n(rst_n), .en(adv),
        .x0(gx0[g]), .x1(gx1[g]), .y0(gy0[g]), .y1(gy1[g]),
        .z0(gz0[g]), .z1(gz1[g]), .r(gr[g]),
        .f0(af0[g]), .f1(af1[g])
      );
    end
    assign bo0[8*k+:8] = sbox8_perm({af0[7], c4b_q.a0});
    assign bo1[8*k+:8] = sbox8_perm({af1[7], c4b_q.a1});
  end
endmodule

// File: tb/tb_skinny_sbox8_dom1_sni_pipelined_lanes.sv
// tb_skinny_sbox8_dom1_sni_pipelined_lanes: scoreboard bench for the masked S-box pipeline.
module tb_skinny_sbox8_dom1_sni_pipelined_lanes;
  localparam int NL = 2;
  localparam int W  = 8 * NL;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, r_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] si0 = '0, si1 = '0, r = '0, bo0, bo1;
`ifdef SKINNY_SBOX8_RAND_CNT_EN
  logic [31:0] rand_cnt;
`endif
  int errors = 0, checks = 0, pops = 0, first_pop = -1, last_pop = -1, cyc = 0, nacc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_log[$];

  skinny_sbox8_dom1_sni_pipelined_lanes #(.NLANES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .r_valid(r_valid),
    .si0(si0), .si1(si1), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .bo0(bo0), .bo1(bo1)
`ifdef SKINNY_SBOX8_RAND_CNT_EN
    , .rand_cnt(rand_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unmasked S8 from its NOR/XOR layer definition and output bit mapping.
  function automatic logic [7:0] s8(input logic [7:0] b);
    logic [7:0] a;
    a[0] = ~(b[7] | b[6]) ^ b[4];
    a[1] = ~(b[3] | b[2]) ^ b[0];
    a[2] = ~(b[2] | b[1]) ^ b[6];
    a[3] = ~(a[0] | a[1]) ^ b[5];
    a[4] = ~(a[1] | b[3]) ^ b[1];
    a[5] = ~(a[2] | a[3]) ^ b[7];
    a[6] = ~(a[3] | a[0]) ^ b[3];
    a[7] = ~(a[4] | a[5]) ^ b[2];
    return {a[3], a[0], a[1], a[6], a[4], a[2], a[5], a[7]};
  endfunction

  function automatic logic [W-1:0] sword(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int k = 0; k < NL; k++) y[8*k+:8] = s8(x[8*k+:8]);
    return y;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] w;
    for (int k = 0; k < NL; k++) w[8*k+:8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the expected result is queued when the word is accepted.
  task automatic step(input logic iv, input logic rv, input logic orr, input logic [W-1:0] x);
    logic [W-1:0] m;
    @(negedge clk);
    m = rnd();
    in_valid = iv; r_valid = rv; out_ready = orr;
    si0 = m; si1 = m ^ x; r = rnd();
    #1;
    if (iv && rv && in_ready) begin
      exp_q.push_back(sword(x));
      nacc++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", bo0 ^ bo1);
      end else check("sbox_out", 64'(bo0 ^ bo1), 64'(exp_q.pop_front()));
      got_log.push_back(bo0 ^ bo1);
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  end

  initial begin
    int lat, base, na0, stale;
    logic [W-1:0] h0, h1, x;
    logic o1, o2, o3;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bo0", 64'(bo0), 64'd0);
    check("rst_bo1", 64'(bo1), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    // Fill: first word must surface after 8 register levels (accepting edge included).
    step(1'b1, 1'b1, 1'b1, {NL{8'h00}});
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      if (out_valid) lat = i;
    end
    check("latency", 64'(lat), 64'd8);
    step(1'b1, 1'b1, 1'b1, {NL{8'h01}});
    step(1'b1, 1'b1, 1'b1, {NL{8'hFF}});
    drain();
    check("fill_count", 64'(got_log.size()), 64'd3);
    if (got_log.size() >= 3) begin
      check("s8_00", 64'(got_log[0]), 64'({NL{8'h65}}));
      check("s8_01", 64'(got_log[1]), 64'({NL{8'h4C}}));
      check("s8_FF", 64'(got_log[2]), 64'({NL{8'hFF}}));
    end
    // Streaming 256 words back to back.
    pops = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 256; i++) begin
      x = rnd();
      x[7:0] = 8'(i);
      step(1'b1, 1'b1, 1'b1, x);
    end
    drain();
    check("stream_count", 64'(pops), 64'd256);
    check("stream_gapless", 64'(last_pop - first_pop), 64'd255);
    // Backpressure: fill with out_ready low, then stall 5 more cycles.
    base = pops;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, rnd());
    check("bp_inflight", 64'(exp_q.size()), 64'd8);
    check("bp_no_pop", 64'(pops - base), 64'd0);
    h0 = bo0; h1 = bo1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, rnd());
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_bo0_hold", 64'(bo0), 64'(h0));
      check("bp_bo1_hold", 64'(bo1), 64'(h1));
    end
    drain();
    check("bp_released", 64'(pops - base), 64'd8);
    // Randomness starvation: r_valid 1,0,1 gives two words and one bubble.
    na0 = nacc;
    step(1'b1, 1'b1, 1'b1, rnd());
    step(1'b1, 1'b0, 1'b1, rnd());
    step(1'b1, 1'b1, 1'b1, rnd());
    check("starve_accepts", 64'(nacc - na0), 64'd2);
    o1 = 1'b0;
    for (int i = 0; i < 20 && !o1; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      o1 = out_valid;
    end
    step(1'b0, 1'b0, 1'b1, '0);
    o2 = out_valid;
    step(1'b0, 1'b0, 1'b1, '0);
    o3 = out_valid;
    check("starve_bubble", 64'({o1, o2, o3}), 64'(3'b101));
    drain();
    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rnd());
    drain();
`ifdef SKINNY_SBOX8_RAND_CNT_EN
    check("rand_cnt", 64'(rand_cnt), 64'(nacc * 8 * NL));
`endif
    // Reset with 4 words in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, rnd());
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_bo0", 64'(bo0), 64'd0);
    check("mid_rst_bo1", 64'(bo1), 64'd0);
`ifdef SKINNY_SBOX8_RAND_CNT_EN
    check("mid_rst_rand_cnt", 64'(rand_cnt), 64'd0);
`endif
    exp_q.delete();
    nacc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      if (out_valid) stale++;
    end
    check("no_stale", 64'(stale), 64'd0);
    step(1'b1, 1'b1, 1'b1, rnd());
    drain();
`ifdef SKINNY_SBOX8_RAND_CNT_EN
    check("rand_cnt_post", 64'(rand_cnt), 64'(8 * NL));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/skinny_sbox8_dom1_sni_pipelined_lanes.md
Name: skinny_sbox8_dom1_sni_pipelined_lanes

Overview:
First-order DOM-Indep masked SKINNY-128 8-bit S-box, NLANES instances in parallel, fully pipelined with valid/ready handshakes and a backpressure stall.
It replaces the non-pipelined single S-box, which needed inputs held stable for the whole evaluation, so the round datapath can stream one masked row or full state per cycle.
Each core-function evaluation is two register levels: independent and cross shares, then compression.

Parameters:
NLANES, 16, number of parallel 8-bit S-boxes (16 = full 128-bit state).
LAT, 8, pipeline latency in accepted-to-valid cycles; fixed to 4 layers x 2 register levels, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  masked input word valid
in_ready  output  1  pipeline can accept this cycle
r_valid  input  1  fresh randomness present on r
si0  input  8*NLANES  share 0; lane k = bits [8k+7:8k]
si1  input  8*NLANES  share 1, same layout
r  input  8*NLANES  refresh mask; lane k bit j feeds gate j of lane k
out_valid  output  1  bo0/bo1 hold a result
out_ready  input  1  consumer accepts result
bo0  output  8*NLANES  output share 0
bo1  output  8*NLANES  output share 1

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0; all share, mask and delay registers 0; out_valid=0; bo0=bo1=0. Reset mid-operation discards all in-flight words.
- adv = ~out_valid | out_ready. in_ready = adv, combinational from out_valid/out_ready only.
- accept = in_valid & r_valid & in_ready.
  - in_valid without r_valid: no accept; a bubble enters.
- When adv=1, every stage register loads. When adv=0, every register holds, including data, masks and valid bits.
- Bubble entry (adv & ~accept): stage-1 shares and masks load zero, never stale port values.
- Per lane, the cfn gate (x,y,z,r) uses shares x0,x1,y0,y1,z0,z1:
  - level A: g1 = ~x1&~y1^z1; g0 = x0&y0^z0; t1 = ~x1&y0^r; t0 = ~y1&x0^r.
  - level B: f = t^g.
- Layer schedule (bi = input bit i, both shares):
  - L1: a0=(b7,b6,b4,r0); a1=(b3,b2,b0,r1); a2=(b2,b1,b6,r2).
  - L2: a3=(a0,a1,b5,r3); a4=(a1,b3,b1,r4).
  - L3: a5=(a2,a3,b7,r5); a6=(a3,a0,b3,r6).
  - L4: a7=(a4,a5,b2,r7).
- Late-used input shares, r bits and intermediate ai are carried in stall-aware delay registers to their layer. The mask is sampled only at accept.
- Output mapping: a0->bit6, a1->bit5, a2->bit2, a3->bit7, a4->bit3, a5->bit1, a6->bit4, a7->bit0.
- Latency: a word accepted at edge n produces out_valid at edge n+8 with no stalls. Each stall cycle adds one.
- Throughput: one word per cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0; out_valid, bo0 and bo1 hold stable until accepted.
- Simultaneous output accept and input accept in one cycle is permitted.
- Correctness: bo0^bo1 = SKINNY S8(si0^si1) per lane, for any r.

Optional Feature:
SKINNY_SBOX8_RAND_CNT_EN
- Defined: adds output rand_cnt [31:0], reset 0. Increments by 8*NLANES on each accept and saturates at 32'hFFFFFFFF. Used to audit randomness consumption against the PRNG.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package skinny_sbox8_pkg: SBOX8_LAT=8, SBOX8_RBITS=8, output bit-permutation constants, and the unmasked reference S8 table (verification only).
- One natural sub-module: dom1_sni_cfn_stall, a single masked cfn gate with enable (2 register levels), instantiated 8 x NLANES.
- The top level holds the valid chain, delay lines and handshake.

Test Plan:
- Reset and fill, NLANES=1: si0=00, si1=00, r=random, both valids high -> out_valid at cycle 8, bo0^bo1=0x65; si0=A5, si1=A4 (x=01) -> 0x4C; x=FF -> 0xFF.
- Streaming: 256 consecutive words x=00..FF, random masks, out_ready=1 -> 256 back-to-back results in order, each S8(x), no bubbles.
- Backpressure: fill the pipe, then out_ready=0 for 5 cycles -> in_ready=0, bo0/bo1 frozen; on release, remaining results appear in order, none lost or duplicated.
- Randomness starvation: in_valid=1, r_valid toggling 1,0,1 -> exactly two words accepted; one bubble seen at the output.
- Reset mid-flight: assert rst_n low with 4 words in flight -> out_valid=0, outputs 0 immediately; no stale word emerges after release.
- NLANES=16 with SKINNY_SBOX8_RAND_CNT_EN: 10 accepts -> rand_cnt=1280; each lane independently matches S8.
